// File: rtl/spi_regfile_slave.sv
// Mode-0 SPI target fronting a DEPTH x DATA_W register file, clocked entirely by sclk.
// Frames are {rw, addr} followed by data words; writes raise a toggle for a core-side synchroniser.
module spi_regfile_slave #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16,
  parameter int MSB_FIRST = 1,
  parameter int AUTO_INC  = 1
) (
  input  logic                      sclk,
  input  logic                      rst_n,
  input  logic                      cs_n,
  input  logic                      mosi,
  output logic                      miso,
  output logic                      miso_oe,
  output logic [DEPTH*DATA_W-1:0]   regs_flat,
  output logic                      wr_toggle,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic                      err
);

  localparam int MAX_BITS = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 1) : DATA_W;
  localparam int CNT_W    = $clog2(MAX_BITS);
  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {ST_CMD = 2'd0, ST_WR = 2'd1, ST_RD = 2'd2} state_t;

  state_t              state_r, state_next_s;
  logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_next_s, tx_idx_s;
  logic [ADDR_W-1:0]   cmd_r, addr_r, addr_next_s, rd_addr_s, wr_addr_r;
  logic [ADDR_W:0]     cmd_full_s;
  logic [DATA_W-1:0]   rx_r, rx_full_s, tx_r, rd_data_s;
  logic [DATA_W-1:0]   regs_r [DEPTH];
  logic                cmd_done_s, word_done_s, rd_ok_s, tx_load_s, tx_bit_s;
  logic                partial_r, miso_r, miso_oe_r, wr_toggle_r, err_r;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X);
  endfunction

  // Framing state: cleared by reset or by deselect
  always_ff @(posedge sclk or negedge rst_n or posedge cs_n) begin
    if (!rst_n) begin
      state_r   <= ST_CMD;
      bit_cnt_r <= '0;
    end else if (cs_n) begin
      state_r   <= ST_CMD;
      bit_cnt_r <= '0;
    end else begin
      state_r   <= state_next_s;
      bit_cnt_r <= bit_cnt_next_s;
    end
  end

  // Next-state and word/command completion decode
  always_comb begin
    state_next_s   = state_r;
    bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
    cmd_done_s     = 1'b0;
    word_done_s    = 1'b0;
    case (state_r)
      ST_CMD: begin
        if (bit_cnt_r == CMD_LAST) begin
          cmd_done_s     = 1'b1;
          bit_cnt_next_s = '0;
          state_next_s   = cmd_full_s[ADDR_W] ? ST_RD : ST_WR;
        end else begin
          state_next_s   = ST_CMD;
        end
      end
      ST_WR, ST_RD: begin
        if (bit_cnt_r == DATA_LAST) begin
          word_done_s    = 1'b1;
          bit_cnt_next_s = '0;
        end else begin
          word_done_s    = 1'b0;
        end
      end
      default: begin
        state_next_s   = ST_CMD;
        bit_cnt_next_s = '0;
      end
    endcase
  end

  // Shift assembly, address stepping and read-word selection
  always_comb begin
    cmd_full_s = {cmd_r, mosi};
    if (MSB_FIRST != 0) begin
      rx_full_s = {rx_r[DATA_W-2:0], mosi};
      tx_idx_s  = DATA_LAST - bit_cnt_r;
    end else begin
      rx_full_s = {mosi, rx_r[DATA_W-1:1]};
      tx_idx_s  = bit_cnt_r;
    end
    if (AUTO_INC != 0) begin
      if (addr_r == ADDR_TOP) begin
        addr_next_s = '0;
      end else begin
        addr_next_s = addr_r + ADDR_W'(1);
      end
    end else begin
      addr_next_s = addr_r;
    end
    rd_addr_s = cmd_done_s ? cmd_full_s[ADDR_W-1:0] : addr_next_s;
    rd_ok_s   = in_range(rd_addr_s);
    rd_data_s = rd_ok_s ? regs_r[rd_addr_s] : '0;
    tx_load_s = (cmd_done_s && (state_next_s == ST_RD)) || (word_done_s && (state_r == ST_RD));
    tx_bit_s  = tx_r[tx_idx_s];
  end

  // Register file, write handshake, error and datapath shift registers
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= '0;
      end
      wr_toggle_r <= 1'b0;
      wr_addr_r   <= '0;
      err_r       <= 1'b0;
      partial_r   <= 1'b0;
      cmd_r       <= '0;
      addr_r      <= '0;
      rx_r        <= '0;
      tx_r        <= '0;
    end else if (!cs_n) begin
      partial_r <= (bit_cnt_next_s != '0);
      // A new frame opening while the previous one ended mid-word flags an error
      if ((state_r == ST_CMD) && (bit_cnt_r == '0) && partial_r) begin
        err_r <= 1'b1;
      end
      if (state_r == ST_CMD) begin
        cmd_r <= cmd_full_s[ADDR_W-1:0];
      end
      if (state_r == ST_WR) begin
        rx_r <= rx_full_s;
      end
      if (cmd_done_s) begin
        addr_r <= cmd_full_s[ADDR_W-1:0];
      end
      if (word_done_s) begin
        addr_r <= addr_next_s;
      end
      if (word_done_s && (state_r == ST_WR)) begin
        if (in_range(addr_r)) begin
          regs_r[addr_r] <= rx_full_s;
          wr_addr_r      <= addr_r;
          wr_toggle_r    <= ~wr_toggle_r;
        end else begin
          err_r <= 1'b1;
        end
      end
      if (tx_load_s) begin
        tx_r <= rd_data_s;
        if (!rd_ok_s) begin
          err_r <= 1'b1;
        end
      end
    end
  end

  // Output enable follows the read phase and drops as soon as cs_n rises
  always_ff @(negedge sclk or negedge rst_n or posedge cs_n) begin
    if (!rst_n) begin
      miso_oe_r <= 1'b0;
    end else if (cs_n) begin
      miso_oe_r <= 1'b0;
    end else begin
      miso_oe_r <= (state_r == ST_RD);
    end
  end

  // Serial data launched on the falling edge
  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      miso_r <= 1'b0;
    end else if (!cs_n && (state_r == ST_RD)) begin
      miso_r <= tx_bit_s;
    end
  end

  // Flatten register file onto the output bus
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      regs_flat[i*DATA_W +: DATA_W] = regs_r[i];
    end
  end

  assign miso      = miso_r;
  assign miso_oe   = miso_oe_r;
  assign wr_toggle = wr_toggle_r;
  assign wr_addr   = wr_addr_r;
  assign err       = err_r;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Drives two spi_regfile_slave variants (MSB-first/auto-inc/16 regs and LSB-first/fixed/10 regs)
// with a shared bit stream and checks both against a frame-level model.
module tb_spi_regfile_slave;

  logic sclk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso0, oe0, tog0, err0, miso1, oe1, tog1, err1;
  logic [3:0]   wa0, wa1;
  logic [127:0] regs0;
  logic [79:0]  regs1;

  spi_regfile_slave #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .MSB_FIRST(1), .AUTO_INC(1)) dut0 (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .mosi(mosi), .miso(miso0), .miso_oe(oe0),
    .regs_flat(regs0), .wr_toggle(tog0), .wr_addr(wa0), .err(err0));

  spi_regfile_slave #(.DATA_W(8), .ADDR_W(4), .DEPTH(10), .MSB_FIRST(0), .AUTO_INC(0)) dut1 (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .mosi(mosi), .miso(miso1), .miso_oe(oe1),
    .regs_flat(regs1), .wr_toggle(tog1), .wr_addr(wa1), .err(err1));

  int n_checks = 0, n_pass = 0;

  // Model state, index 0/1 per DUT
  logic [7:0] m_reg [2][16];
  logic       m_tog [2];
  logic       m_err [2];
  logic [3:0] m_wa  [2];
  logic [3:0] m_addr[2];
  logic [7:0] m_tx  [2];
  logic       m_partial;
  logic [63:0] rd0, rd1;

  function automatic int p_depth(input int d); return (d == 0) ? 16 : 10; endfunction
  function automatic bit p_msb(input int d);   return (d == 0); endfunction
  function automatic bit p_inc(input int d);   return (d == 0); endfunction

  // Byte value from 8 bits in arrival order
  function automatic logic [7:0] assemble(input int d, input logic [7:0] chunk);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = p_msb(d) ? chunk[7-i] : chunk[i];
    return w;
  endfunction

  // Serial stream (first bit at index 0) sending bytes MSB first
  function automatic logic [63:0] stream2(input logic [7:0] b0, input logic [7:0] b1);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i]     = b0[7-i];
      s[8 + i] = b1[7-i];
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic m_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) m_reg[d][i] = 8'h00;
      m_tog[d] = 1'b0; m_err[d] = 1'b0; m_wa[d] = 4'h0; m_addr[d] = 4'h0; m_tx[d] = 8'h00;
    end
    m_partial = 1'b0;
  endtask

  task automatic m_load(input int d);
    if (int'(m_addr[d]) < p_depth(d)) m_tx[d] = m_reg[d][m_addr[d]];
    else begin
      m_tx[d]  = 8'h00;
      m_err[d] = 1'b1;
    end
  endtask

  task automatic m_step_addr(input int d);
    if (p_inc(d)) m_addr[d] = (int'(m_addr[d]) == p_depth(d) - 1) ? 4'h0 : m_addr[d] + 4'h1;
  endtask

  function automatic logic exp_bit(input int d, input int q);
    return p_msb(d) ? m_tx[d][7-q] : m_tx[d][q];
  endfunction

  task automatic check_state(input logic exp_oe);
    logic [127:0] e0;
    logic [79:0]  e1;
    for (int i = 0; i < 16; i++) e0[i*8 +: 8] = m_reg[0][i];
    for (int i = 0; i < 10; i++) e1[i*8 +: 8] = m_reg[1][i];
    chk("regs0", regs0, e0);         chk("regs1", {48'h0, regs1}, {48'h0, e1});
    chk("tog0", tog0, m_tog[0]);     chk("tog1", tog1, m_tog[1]);
    chk("waddr0", wa0, m_wa[0]);     chk("waddr1", wa1, m_wa[1]);
    chk("err0", err0, m_err[0]);     chk("err1", err1, m_err[1]);
    chk("oe0", oe0, exp_oe);         chk("oe1", oe1, exp_oe);
  endtask

  // One mode-0 bit: data set while sclk low, sampled on rise; leaves us 2 units after the fall
  task automatic bit_cycle(input logic b);
    mosi = b; #3; sclk = 1'b1; #3; sclk = 1'b0; #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cs_n = 1'b1; mosi = 1'b0; #5;
    m_clear();
    check_state(1'b0);
    chk("rst_miso0", miso0, 1'b0);   chk("rst_miso1", miso1, 1'b0);
    rst_n = 1'b1; #5;
  endtask

  task automatic frame(input logic rw, input logic [3:0] a, input int ncmd, input int nbits,
                       input logic [63:0] wbits);
    logic [4:0] cmd;
    logic b;
    int q;
    cmd = {rw, a}; rd0 = '0; rd1 = '0;
    cs_n = 1'b0; #2;
    for (int i = 0; i < ncmd; i++) begin
      bit_cycle(cmd[4-i]);
      if (i == 0 && m_partial) begin m_err[0] = 1'b1; m_err[1] = 1'b1; end
      if (i == 4) for (int d = 0; d < 2; d++) begin
        m_addr[d] = a;
        if (rw) m_load(d);
      end
      m_partial = (i != 4);
      check_state(rw && (i == 4));
      if (rw && i == 4) begin
        chk("miso0_first", miso0, exp_bit(0, 0));
        chk("miso1_first", miso1, exp_bit(1, 0));
      end
    end
    if (ncmd == 5) for (int j = 0; j < nbits; j++) begin
      b = rw ? 1'($urandom_range(0, 1)) : wbits[j];
      rd0 = {rd0[62:0], miso0};
      rd1 = {rd1[62:0], miso1};
      bit_cycle(b);
      q = j % 8;
      if (q == 7) for (int d = 0; d < 2; d++) begin
        if (!rw) begin
          if (int'(m_addr[d]) < p_depth(d)) begin
            m_reg[d][m_addr[d]] = assemble(d, wbits[j-7 +: 8]);
            m_tog[d] = ~m_tog[d];
            m_wa[d]  = m_addr[d];
          end else m_err[d] = 1'b1;
        end
        m_step_addr(d);
        if (rw) m_load(d);
      end
      m_partial = (q != 7);
      check_state(rw);
      if (rw) begin
        chk("miso0", miso0, exp_bit(0, (j + 1) % 8));
        chk("miso1", miso1, exp_bit(1, (j + 1) % 8));
      end
    end
    cs_n = 1'b1; #2;
    check_state(1'b0);
  endtask

  initial begin
    m_clear();
    do_reset();

    // Single write, then a second word-frame to reg4, then a 2-word burst read
    frame(1'b0, 4'd3, 5, 8, stream2(8'hA5, 8'h00));
    chk("lit_reg3_d0", regs0[31:24], 8'hA5);   chk("lit_reg3_d1", regs1[31:24], 8'hA5);
    chk("lit_wa0", wa0, 4'd3);                 chk("lit_tog0", tog0, 1'b1);
    chk("lit_err0", err0, 1'b0);
    frame(1'b0, 4'd4, 5, 8, stream2(8'h3C, 8'h00));
    frame(1'b1, 4'd3, 5, 16, 64'h0);
    chk("lit_burst_rd0", rd0[15:0], 16'hA53C);  chk("lit_burst_rd1", rd1[15:0], 16'hA5A5);

    // Aborted write frame followed by a readback
    frame(1'b0, 4'd2, 5, 8, stream2(8'h5A, 8'h00));
    frame(1'b0, 4'd2, 5, 3, stream2(8'hFF, 8'h00));
    chk("lit_abort_err_before", err0, 1'b0);
    frame(1'b1, 4'd2, 5, 8, 64'h0);
    chk("lit_abort_err0", err0, 1'b1);         chk("lit_abort_err1", err1, 1'b1);
    chk("lit_abort_rd0", rd0[7:0], 8'h5A);

    // Burst write wrapping 15 -> 0 (out of range for the 10-register variant)
    do_reset();
    frame(1'b0, 4'd15, 5, 16, stream2(8'h11, 8'h22));
    chk("lit_wrap_r15", regs0[127:120], 8'h11); chk("lit_wrap_r0", regs0[7:0], 8'h22);
    chk("lit_wrap_tog0", tog0, 1'b0);           chk("lit_wrap_err1", err1, 1'b1);

    // Out-of-range address 12 on the 10-register variant
    do_reset();
    frame(1'b0, 4'd12, 5, 8, stream2(8'h77, 8'h00));
    chk("lit_oor_tog1", tog1, 1'b0);            chk("lit_oor_err1", err1, 1'b1);
    chk("lit_oor_tog0", tog0, 1'b1);
    frame(1'b1, 4'd12, 5, 8, 64'h0);
    chk("lit_oor_rd1", rd1[7:0], 8'h00);        chk("lit_oor_rd0", rd0[7:0], 8'h77);

    // Reset asserted in the middle of a read frame
    cs_n = 1'b0; #2;
    for (int i = 0; i < 5; i++) bit_cycle(i == 0 || i >= 3);
    for (int i = 0; i < 3; i++) bit_cycle(1'b0);
    chk("lit_mid_oe0", oe0, 1'b1);
    rst_n = 1'b0; #1;
    m_clear();
    check_state(1'b0);
    chk("mid_rst_miso0", miso0, 1'b0);          chk("mid_rst_miso1", miso1, 1'b0);
    #2; rst_n = 1'b1; #2; cs_n = 1'b1; #2;

    // Randomised frames, including aborted command and data phases
    for (int f = 0; f < 40; f++) begin
      frame(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 5,
            int'($urandom_range(0, 24)), {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
